// File: rtl/sign_render_pkg.sv
// Shared constants for the synthetic hand-frame renderer: frame geometry,
// skin region bounds, finger bit positions and FSM encoding.
package sign_render_pkg;

   localparam int FRAME_W = 64;
   localparam int FRAME_H = 64;
   localparam logic [5:0] LAST_COL = 6'(FRAME_W - 1);
   localparam logic [5:0] LAST_ROW = 6'(FRAME_H - 1);

   localparam int PALM_ROW_LO = 40;
   localparam int PALM_ROW_HI = 63;
   localparam int PALM_COL_LO = 16;
   localparam int PALM_COL_HI = 47;

   // Finger bars share row bounds; a folded finger keeps only the stub rows.
   localparam int FINGER_ROW_LO = 16;
   localparam int FINGER_ROW_HI = 39;
   localparam int STUB_ROW_LO   = 34;
   localparam int FINGER_WIDTH  = 6;
   localparam int INDEX_COL_LO  = 17;
   localparam int MIDDLE_COL_LO = 25;
   localparam int RING_COL_LO   = 33;
   localparam int PINKY_COL_LO  = 41;

   localparam int THUMB_ROW_LO = 44;
   localparam int THUMB_ROW_HI = 49;
   localparam int THUMB_COL_LO = 4;
   localparam int THUMB_COL_HI = 15;

   localparam int BIT_THUMB  = 0;
   localparam int BIT_INDEX  = 1;
   localparam int BIT_MIDDLE = 2;
   localparam int BIT_RING   = 3;
   localparam int BIT_PINKY  = 4;

   localparam int MAX_CODE = 31;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_RENDER = 1'b1
   } state_t;

   function automatic logic in_range(input logic [5:0] v, input int lo, input int hi);
      return (int'(v) >= lo) && (int'(v) <= hi);
   endfunction

endpackage

// File: rtl/sign_pixel_shader.sv
// Combinational skin/background classifier for one (row, col) position of
// the hand frame, given the finger bits and the invalid-code flag.
module sign_pixel_shader
   import sign_render_pkg::*;
(
   input  logic [5:0] row,
   input  logic [5:0] col,
   input  logic [4:0] fingers,
   input  logic       error,
   output logic       is_skin
);

   logic       palm;
   logic       thumb;
   logic [3:0] bar;

   function automatic logic finger_bar(input logic [5:0] r, input logic [5:0] c,
                                       input int col_lo, input logic extended);
      int row_lo;
      row_lo = extended ? FINGER_ROW_LO : STUB_ROW_LO;
      return in_range(c, col_lo, col_lo + FINGER_WIDTH - 1) &&
             in_range(r, row_lo, FINGER_ROW_HI);
   endfunction

   always_comb begin
      palm   = in_range(row, PALM_ROW_LO, PALM_ROW_HI) &&
               in_range(col, PALM_COL_LO, PALM_COL_HI);
      thumb  = fingers[BIT_THUMB] &&
               in_range(row, THUMB_ROW_LO, THUMB_ROW_HI) &&
               in_range(col, THUMB_COL_LO, THUMB_COL_HI);
      bar[0] = finger_bar(row, col, INDEX_COL_LO,  fingers[BIT_INDEX]);
      bar[1] = finger_bar(row, col, MIDDLE_COL_LO, fingers[BIT_MIDDLE]);
      bar[2] = finger_bar(row, col, RING_COL_LO,   fingers[BIT_RING]);
      bar[3] = finger_bar(row, col, PINKY_COL_LO,  fingers[BIT_PINKY]);
      // An invalid code blanks the whole frame regardless of finger bits.
      is_skin = !error && (palm || thumb || (|bar));
   end

endmodule

// File: rtl/sign_frame_renderer.sv
// Renders a 64x64 RGB hand frame for a sign code as a valid/ready pixel
// stream; pixel registers are loaded one pixel ahead from the shader.
module sign_frame_renderer
   import sign_render_pkg::*;
#(
   parameter logic [23:0] SKIN_RGB = 24'hE0AC8C,
   parameter logic [23:0] BG_RGB   = 24'h000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] sign_value,
   input  logic       sign_valid,
   output logic       sign_ready,
   output logic [7:0] red_ch,
   output logic [7:0] green_ch,
   output logic [7:0] blue_ch,
   output logic       pix_valid,
   input  logic       pix_ready,
   output logic       frame_start,
   output logic       line_end,
   output logic       frame_done,
   output logic       code_error,
   output logic       fsm_state
);

   // Handshakes: a word moves on any rising edge where valid && ready; the
   // producer holds valid and its payload stable until that edge.
   state_t     state;
   logic       armed;
   logic [5:0] row;
   logic [5:0] col;
   logic [4:0] code_q;

   logic       accept;
   logic       xfer;
   logic       last_xfer;
   logic [5:0] nxt_row;
   logic [5:0] nxt_col;
   logic [4:0] shade_fingers;
   logic       shade_err;
   logic       is_skin;
   logic [23:0] shade_rgb;

   // armed keeps sign_ready low during reset and for the release cycle.
   assign sign_ready = armed && (state == ST_IDLE);
   assign fsm_state  = (state == ST_RENDER);
   assign accept     = sign_valid && sign_ready;
   assign xfer       = pix_valid && pix_ready;
   assign last_xfer  = xfer && (row == LAST_ROW) && (col == LAST_COL);

   always_comb begin
      nxt_row       = row;
      nxt_col       = col + 6'd1;
      shade_fingers = code_q;
      shade_err     = code_error;
      if (accept) begin
         nxt_row       = 6'd0;
         nxt_col       = 6'd0;
         shade_fingers = sign_value[4:0];
         shade_err     = (sign_value > 8'(MAX_CODE));
      end else if (col == LAST_COL) begin
         nxt_row = row + 6'd1;
      end
   end

   sign_pixel_shader u_shader (
      .row     (nxt_row),
      .col     (nxt_col),
      .fingers (shade_fingers),
      .error   (shade_err),
      .is_skin (is_skin)
   );

   assign shade_rgb = is_skin ? SKIN_RGB : BG_RGB;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         armed       <= 1'b0;
         row         <= 6'd0;
         col         <= 6'd0;
         code_q      <= 5'd0;
         code_error  <= 1'b0;
         red_ch      <= 8'd0;
         green_ch    <= 8'd0;
         blue_ch     <= 8'd0;
         pix_valid   <= 1'b0;
         frame_start <= 1'b0;
         line_end    <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         armed      <= 1'b1;
         frame_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  code_q      <= sign_value[4:0];
                  code_error  <= shade_err;
                  row         <= 6'd0;
                  col         <= 6'd0;
                  {red_ch, green_ch, blue_ch} <= shade_rgb;
                  pix_valid   <= 1'b1;
                  frame_start <= 1'b1;
                  line_end    <= 1'b0;
                  state       <= ST_RENDER;
               end
            end
            ST_RENDER: begin
               if (last_xfer) begin
                  pix_valid   <= 1'b0;
                  frame_start <= 1'b0;
                  line_end    <= 1'b0;
                  frame_done  <= 1'b1;
                  state       <= ST_IDLE;
               end else if (xfer) begin
                  row         <= nxt_row;
                  col         <= nxt_col;
                  {red_ch, green_ch, blue_ch} <= shade_rgb;
                  frame_start <= 1'b0;
                  line_end    <= (nxt_col == LAST_COL);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sign_frame_renderer.sv
// Bench for sign_frame_renderer: table-driven frames, random codes with
// backpressure against a painted-bitmap model, back-to-back and reset cases.
module tb_sign_frame_renderer;

   localparam logic [23:0] SKIN = 24'hE0AC8C;
   localparam logic [23:0] BG   = 24'h000000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sign_value;
   logic       sign_valid;
   logic       sign_ready;
   logic [7:0] red_ch, green_ch, blue_ch;
   logic       pix_valid;
   logic       pix_ready;
   logic       frame_start, line_end, frame_done, code_error;
   logic       fsm_state;

   sign_frame_renderer dut (
      .clk         (clk),
      .rst         (rst),
      .sign_value  (sign_value),
      .sign_valid  (sign_valid),
      .sign_ready  (sign_ready),
      .red_ch      (red_ch),
      .green_ch    (green_ch),
      .blue_ch     (blue_ch),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .frame_start (frame_start),
      .line_end    (line_end),
      .frame_done  (frame_done),
      .code_error  (code_error),
      .fsm_state   (fsm_state)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic model_img [64][64];
   logic got_img   [64][64];
   logic [23:0] exp_q[$];

   int xfers, skin_cnt, fs_cnt, le_cnt, fd_cnt, mism, stall_err, pos_err, err_cnt, gap_err;

   typedef struct {
      logic [7:0] code;
      int         bp;
      int         skin;
      int         err;
   } vec_t;
   vec_t vecs [6];

   task automatic check_eq(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic paint(input int r0, input int r1, input int c0, input int c1);
      for (int r = r0; r <= r1; r++)
         for (int c = c0; c <= c1; c++)
            model_img[r][c] = 1'b1;
   endtask

   // Reference picture: paint each hand part as a rectangle onto a blank canvas.
   task automatic build_model(input logic [7:0] code);
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 64; c++)
            model_img[r][c] = 1'b0;
      if (code <= 8'd31) begin
         paint(40, 63, 16, 47);
         for (int f = 0; f < 4; f++)
            paint(code[f+1] ? 16 : 34, 39, 17 + 8*f, 22 + 8*f);
         if (code[0]) paint(44, 49, 4, 15);
      end
   endtask

   function automatic int model_skin_total();
      int n = 0;
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 64; c++)
            if (model_img[r][c]) n++;
      return n;
   endfunction

   task automatic send_code(input logic [7:0] code);
      int n = 0;
      while (!sign_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("sign_ready_wait", int'(sign_ready), 1);
      sign_valid = 1'b1;
      sign_value = code;
      @(negedge clk);
      sign_valid = 1'b0;
      sign_value = 8'($urandom);
   endtask

   // Entered at the negedge where pixel (0,0) must be presented; returns at
   // the negedge just after the last transfer.
   task automatic run_frame(input logic [7:0] code, input int bp);
      logic [23:0] px;
      logic [23:0] exp_px;
      logic [25:0] hold;
      bit          have_hold;
      int          cyc;
      int          exp_err;
      exp_err = (code > 8'd31) ? 1 : 0;
      build_model(code);
      exp_q.delete();
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 64; c++)
            exp_q.push_back(model_img[r][c] ? SKIN : BG);
      xfers = 0; skin_cnt = 0; fs_cnt = 0; le_cnt = 0; fd_cnt = 0;
      mism = 0; stall_err = 0; pos_err = 0; err_cnt = 0; gap_err = 0;
      check_eq("first_pix_valid", int'(pix_valid), 1);
      check_eq("first_frame_start", int'(frame_start), 1);
      check_eq("code_error_t1", int'(code_error), exp_err);
      have_hold = 1'b0;
      cyc = 0;
      while (xfers < 4096 && cyc < 20000) begin
         px = {red_ch, green_ch, blue_ch};
         if (have_hold && {px, frame_start, line_end} != hold) stall_err++;
         pix_ready = (bp == 0) ? 1'b1 : ($urandom_range(0, 99) >= 32'(bp));
         if (frame_done) fd_cnt++;
         if (!pix_valid) begin
            gap_err++;
            have_hold = 1'b0;
         end else if (pix_ready) begin
            exp_px = exp_q.pop_front();
            if (px != exp_px) begin
               if (mism == 0)
                  $display("FAIL pixel_%0d: got %06h, required %06h", xfers, px, exp_px);
               mism++;
            end
            got_img[xfers/64][xfers%64] = (px == SKIN);
            if (px == SKIN) skin_cnt++;
            if (frame_start) fs_cnt++;
            if (line_end) le_cnt++;
            if (frame_start != (xfers == 0) || line_end != (xfers % 64 == 63)) pos_err++;
            if (int'(code_error) != exp_err) err_cnt++;
            xfers++;
            have_hold = 1'b0;
         end else begin
            have_hold = 1'b1;
            hold = {px, frame_start, line_end};
         end
         @(negedge clk);
         cyc++;
      end
      check_eq("transfers", xfers, 4096);
      check_eq("stream_mismatches", mism, 0);
      check_eq("stall_stability", stall_err, 0);
      check_eq("valid_gaps", gap_err, 0);
      check_eq("frame_start_count", fs_cnt, 1);
      check_eq("line_end_count", le_cnt, 64);
      check_eq("marker_positions", pos_err, 0);
      check_eq("code_error_in_frame", err_cnt, 0);
      check_eq("early_frame_done", fd_cnt, 0);
      check_eq("end_pix_valid", int'(pix_valid), 0);
      check_eq("end_frame_done", int'(frame_done), 1);
      check_eq("end_sign_ready", int'(sign_ready), 1);
      pix_ready = 1'b1;
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time exhausted");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int row_skin;
      logic [7:0] rc;

      vecs[0] = '{code: 8'h1F, bp: 0,  skin: 1416, err: 0};
      vecs[1] = '{code: 8'h00, bp: 0,  skin: 912,  err: 0};
      vecs[2] = '{code: 8'h40, bp: 0,  skin: 0,    err: 1};
      vecs[3] = '{code: 8'h0A, bp: 30, skin: 1128, err: 0};
      vecs[4] = '{code: 8'h01, bp: 0,  skin: 984,  err: 0};
      vecs[5] = '{code: 8'hFF, bp: 30, skin: 0,    err: 1};

      rst = 1'b1;
      sign_valid = 1'b0;
      sign_value = 8'd0;
      pix_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset_outputs",
               int'({pix_valid, frame_start, line_end, frame_done, code_error,
                     red_ch, green_ch, blue_ch}), 0);
      check_eq("reset_sign_ready", int'(sign_ready), 0);
      rst = 1'b0;
      #1;
      check_eq("release_sign_ready", int'(sign_ready), 0);
      @(negedge clk);
      check_eq("armed_sign_ready", int'(sign_ready), 1);

      for (int i = 0; i < 6; i++) begin
         send_code(vecs[i].code);
         run_frame(vecs[i].code, vecs[i].bp);
         check_eq("skin_count", skin_cnt, vecs[i].skin);
         check_eq("code_error_after", int'(code_error), vecs[i].err);
         @(negedge clk);
         check_eq("frame_done_width", int'(frame_done), 0);
         case (vecs[i].code)
            8'h1F: begin
               check_eq("pt_20_20", int'(got_img[20][20]), 1);
               check_eq("pt_20_23", int'(got_img[20][23]), 0);
               check_eq("pt_46_10", int'(got_img[46][10]), 1);
            end
            8'h00: begin
               row_skin = 0;
               for (int c = 0; c < 64; c++) if (got_img[20][c]) row_skin++;
               check_eq("row20_skin", row_skin, 0);
               check_eq("pt_36_18", int'(got_img[36][18]), 1);
            end
            default: ;
         endcase
      end

      for (int k = 0; k < 3; k++) begin
         rc = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(32, 255))
                                          : 8'($urandom_range(0, 31));
         send_code(rc);
         run_frame(rc, 35);
         check_eq("rand_skin_count", skin_cnt, model_skin_total());
      end

      // Back-to-back: sign_valid stays high, code changes mid-frame.
      @(negedge clk);
      sign_valid = 1'b1;
      sign_value = 8'd3;
      @(negedge clk);
      sign_value = 8'd24;
      run_frame(8'd3, 0);
      @(negedge clk);
      sign_valid = 1'b0;
      run_frame(8'd24, 0);
      check_eq("b2b_pt_20_18", int'(got_img[20][18]), 0);
      check_eq("b2b_pt_20_26", int'(got_img[20][26]), 0);
      check_eq("b2b_pt_20_34", int'(got_img[20][34]), 1);
      check_eq("b2b_pt_20_42", int'(got_img[20][42]), 1);
      check_eq("b2b_pt_46_10", int'(got_img[46][10]), 0);

      // Reset in the middle of an invalid-code frame.
      send_code(8'hC0);
      n = 0;
      for (int c = 0; c < 1200 && n < 1000; c++) begin
         pix_ready = 1'b1;
         if (pix_valid) n++;
         @(negedge clk);
      end
      check_eq("pre_reset_pixels", n, 1000);
      check_eq("pre_reset_code_error", int'(code_error), 1);
      #2 rst = 1'b1;
      #1;
      check_eq("async_reset_outputs",
               int'({pix_valid, frame_start, line_end, frame_done, code_error,
                     red_ch, green_ch, blue_ch}), 0);
      check_eq("async_reset_sign_ready", int'(sign_ready), 0);
      n = 0;
      repeat (3) begin
         @(negedge clk);
         if (frame_done) n++;
      end
      rst = 1'b0;
      #1;
      check_eq("rerelease_sign_ready", int'(sign_ready), 0);
      @(negedge clk);
      if (frame_done) n++;
      check_eq("abandoned_frame_done", n, 0);
      check_eq("rearmed_sign_ready", int'(sign_ready), 1);
      rc = 8'($urandom_range(0, 31));
      send_code(rc);
      run_frame(rc, 20);
      check_eq("post_reset_skin", skin_cnt, model_skin_total());

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/sign_frame_renderer.md
# sign_frame_renderer

Inverse of the sign-recognition pipeline: takes a sign code and renders a synthetic 64x64 RGB hand frame in which each finger is drawn either extended or folded. It drives the same 8-bit red_ch/green_ch/blue_ch pixel stream that the recognizer consumes. It is used as a closed-loop stimulus source for the recognizer and as an on-screen echo of the recognized sign.

## Interface
Parameters:
- SKIN_RGB, 24'hE0AC8C: colour of hand pixels, as {R,G,B}.
- BG_RGB, 24'h000000: colour of background pixels.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- sign_value  in  8  sign code.
  - Bits [4:0] are {pinky, ring, middle, index, thumb}; 1 = extended.
  - Codes above 31 are invalid.
- sign_valid  in  1  sign_value is offered.
- sign_ready  out  1  renderer is idle and accepts a code.
- red_ch, green_ch, blue_ch  out  8 each  current pixel.
- pix_valid  out  1  pixel outputs hold a valid pixel.
- pix_ready  in  1  downstream accepts the pixel.
- frame_start  out  1  qualifies pixel (row 0, col 0).
- line_end  out  1  qualifies the pixel in col 63.
- frame_done  out  1  one-cycle pulse after the last pixel transfer.
- code_error  out  1  the current or last frame came from an invalid code.

## Operation
- FSM has two states:
  - IDLE: sign_ready=1.
  - RENDER: sign_ready=0.
- Accept: a code is accepted when sign_valid && sign_ready.
  - sign_value is latched.
  - code_error is set to (sign_value > 31).
  - row and col are cleared.
  - The pixel output registers load pixel (0,0).
  - FSM goes to RENDER.
- Transfer: a pixel transfers when pix_valid && pix_ready.
  - col increments; at 63 it wraps to 0 and row increments.
  - The output registers load the next pixel.
- Last transfer: at row 63 / col 63, FSM goes to IDLE, pix_valid drops and frame_done pulses.
- Stall: while pix_valid && !pix_ready, all pixel outputs, frame_start and line_end hold stable.
- Classification: a pixel is skin if it lies in any of the regions below; otherwise it is background. Coordinates are (row, col), inclusive.
  - Palm: rows 40..63, cols 16..47.
  - Finger bars: index cols 17..22, middle 25..30, ring 33..38, pinky 41..46.
    - Extended: rows 16..39.
    - Folded: stub rows 34..39.
  - Thumb, extended only: rows 44..49, cols 4..15. A folded thumb draws nothing.
- Invalid code: the whole frame is BG_RGB with code_error=1. code_error holds until the next accept.
- sign_valid is ignored in RENDER. The latched code cannot change mid-frame.

## Timing
- Reset values: state IDLE.
  - sign_ready=0; it rises in the first clock after reset release.
  - pix_valid=0, frame_start=0, line_end=0, frame_done=0, code_error=0.
  - red_ch, green_ch, blue_ch = 0.
- Reset mid-frame: outputs drop immediately (asynchronous). The partial frame is abandoned, with no frame_done.
- Latency: accept in cycle T, then pix_valid=1 with pixel (0,0) and frame_start=1 in T+1.
- Throughput: with pix_ready held at 1, one pixel per cycle. 4096 cycles from T+1 to the last pixel.
- End of frame: last transfer in cycle L.
  - In L+1: pix_valid=0, frame_done=1, sign_ready=1.
  - A code accepted in L+1 gives its first pixel in L+2.
- Pixel registers: every colour output comes from a registered pixel path, with no combinational path from the input ports.
  - sign_ready is a direct decode of the state register.

## Structure
- Shared include/package sign_render_pkg:
  - Frame size constants 64x64.
  - All region bounds above.
  - Finger bit indices.
  - Max valid code 31.
  - FSM state encodings.
- One sub-module, sign_pixel_shader: combinational; inputs (row, col, finger bits, error), output is_skin.
- Top level: FSM, counters, handshake and output registers.

## Test plan
- Code 5'b11111 at pix_ready=1 -> 4096 transfers.
  - Exactly 1416 SKIN_RGB pixels (768 palm + 576 fingers + 72 thumb).
  - (20,20) skin, (20,23) background, (46,10) skin.
- Code 0 -> 912 skin pixels; row 20 all background; (36,18) skin; code_error=0.
- Code 8'h40 -> code_error=1 from T+1; 0 skin pixels; frame_done still pulses after 4096 transfers.
- Random pix_ready backpressure -> outputs stable across every stall; 4096 transfers; frame_start once; line_end 64 times; frame_done once.
- sign_valid held high with codes 3 then 24 -> second frame's pixel (0,0) two cycles after the first frame's last transfer.
  - Second frame: (20,18) background, (20,26) background, (20,34) skin, (20,42) skin, (46,10) background.
- Assert rst at pixel 1000 -> all outputs 0 immediately; no frame_done; sign_ready=1 one cycle after release; a new code renders a full frame.
